// File: rtl/mpc_config_ctrl.sv
// Configuration controller for the 2x2 multi-project array: serial shadow load, commit
// validation, and a break-before-make switch of the shared configuration bus.
module mpc_config_ctrl #(
  parameter int unsigned CFG_W        = 4,
  parameter int unsigned MAX_CFG      = 3,
  parameter int unsigned RESET_CFG    = 0,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_en,
  input  logic             scan_din,
  output logic             scan_dout,
  input  logic             scan_commit,
  output logic [CFG_W-1:0] configuration,
  output logic             oe_gate,
  output logic             busy,
  output logic             cfg_valid,
  output logic             err_invalid,
  output logic             err_busy
);

  localparam int unsigned BitW   = $clog2(CFG_W + 1);
  localparam int unsigned GuardW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  localparam logic [BitW-1:0]   BitFull   = BitW'(CFG_W);
  localparam logic [GuardW-1:0] GuardLast = GuardW'(GUARD_CYCLES - 1);
  localparam logic [CFG_W-1:0]  MaxCfg    = CFG_W'(MAX_CFG);
  localparam logic [CFG_W-1:0]  ResetCfg  = CFG_W'(RESET_CFG);

  typedef enum logic [1:0] {StIdle, StGateOff, StSettle} state_e;

  state_e            state_q, state_d;
  logic [GuardW-1:0] guard_q, guard_d;
  logic [CFG_W-1:0]  shadow_q, shadow_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CFG_W-1:0]  target_q, target_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic              oe_gate_q, oe_gate_d;
  logic              busy_q, busy_d;
  logic              cfg_valid_q, cfg_valid_d;
  logic              err_invalid_q, err_invalid_d;
  logic              err_busy_q, err_busy_d;
  logic              idle_commit;

  assign idle_commit = scan_commit && (state_q == StIdle);

  always_comb begin
    state_d       = state_q;
    guard_d       = guard_q;
    shadow_d      = shadow_q;
    bit_cnt_d     = bit_cnt_q;
    target_d      = target_q;
    cfg_d         = cfg_q;
    cfg_valid_d   = cfg_valid_q;
    err_invalid_d = err_invalid_q;
    err_busy_d    = err_busy_q;

    // A commit in IDLE together with scan_en is rejected and suppresses the shift.
    if (scan_en && !idle_commit) begin
      shadow_d = {scan_din, shadow_q[CFG_W-1:1]};
      if (bit_cnt_q != BitFull) begin
        bit_cnt_d = bit_cnt_q + BitW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (scan_commit) begin
          bit_cnt_d = '0;
          if (scan_en) begin
            err_invalid_d = 1'b1;
          end else if ((bit_cnt_q != BitFull) || (shadow_q > MaxCfg)) begin
            err_invalid_d = 1'b1;
          end else begin
            err_invalid_d = 1'b0;
            err_busy_d    = 1'b0;
            cfg_valid_d   = 1'b1;
            if (shadow_q != cfg_q) begin
              target_d = shadow_q;
              guard_d  = GuardLast;
              state_d  = StGateOff;
            end
          end
        end
      end
      StGateOff: begin
        if (scan_commit) begin
          err_busy_d = 1'b1;
        end
        if (guard_q == '0) begin
          cfg_d   = target_q;
          guard_d = GuardLast;
          state_d = StSettle;
        end else begin
          guard_d = guard_q - GuardW'(1);
        end
      end
      StSettle: begin
        if (scan_commit) begin
          err_busy_d = 1'b1;
        end
        if (guard_q == '0) begin
          state_d = StIdle;
        end else begin
          guard_d = guard_q - GuardW'(1);
        end
      end
      default: begin
        state_d = StSettle;
        guard_d = GuardLast;
      end
    endcase

    // Gate and busy are registered copies of the next state, so they toggle with the FSM.
    oe_gate_d = (state_d == StIdle);
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StSettle;
      guard_q       <= GuardLast;
      shadow_q      <= '0;
      bit_cnt_q     <= '0;
      target_q      <= ResetCfg;
      cfg_q         <= ResetCfg;
      oe_gate_q     <= 1'b0;
      busy_q        <= 1'b1;
      cfg_valid_q   <= 1'b0;
      err_invalid_q <= 1'b0;
      err_busy_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      guard_q       <= guard_d;
      shadow_q      <= shadow_d;
      bit_cnt_q     <= bit_cnt_d;
      target_q      <= target_d;
      cfg_q         <= cfg_d;
      oe_gate_q     <= oe_gate_d;
      busy_q        <= busy_d;
      cfg_valid_q   <= cfg_valid_d;
      err_invalid_q <= err_invalid_d;
      err_busy_q    <= err_busy_d;
    end
  end

  assign scan_dout     = shadow_q[0];
  assign configuration = cfg_q;
  assign oe_gate       = oe_gate_q;
  assign busy          = busy_q;
  assign cfg_valid     = cfg_valid_q;
  assign err_invalid   = err_invalid_q;
  assign err_busy      = err_busy_q;

endmodule
